// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS front end: reset/vector addresses,
// the nop encoding and the next-PC source select.
package mips_pkg;

  localparam int          PC_W         = 32;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] IRQ_VEC_DEF  = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC_DEF  = 32'h8000_0008;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_REDIR,
    SEL_IRQ,
    SEL_EXC,
    SEL_HOLD
  } npc_sel_e;

endpackage

// File: rtl/instruction_fetch_if_id.sv
// IF/ID pipeline register: loads a fetched word, holds on stall, or inserts a
// bubble (valid=0, instr=nop, pc_plus4=0).
module if_id_reg
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            hold,
  input  logic            bubble,
  input  logic [PC_W-1:0] instr_d,
  input  logic [PC_W-1:0] pc_plus4_d,
  output logic            valid,
  output logic [PC_W-1:0] instr,
  output logic [PC_W-1:0] pc_plus4
);

  // Bubble wins over hold so a vector entry during a stall still squashes.
  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      valid    <= 1'b0;
      instr    <= NOP_INSTR;
      pc_plus4 <= '0;
    end else if (!hold) begin
      valid    <= 1'b1;
      instr    <= instr_d;
      pc_plus4 <= pc_plus4_d;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC register, next-PC arbitration (exc > redirect > irq > stall > seq),
// epc capture and kernel bit. Optional perf counters under FETCH_PERF_EN.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] IRQ_VEC    = IRQ_VEC_DEF,
  parameter logic [31:0] EXC_VEC    = EXC_VEC_DEF,
  parameter int          DELAY_SLOT = 0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        exc,
  input  logic        irq,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] epc,
  output logic        epc_we,
  output logic        kernel
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_bubble
`endif
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  npc_sel_e    sel;
  logic        exc_take;
  logic        redir_take;
  logic        irq_take;
  logic        load_valid;
  logic        ifid_hold;
  logic        ifid_bubble;

  assign imem_addr = pc;
  assign kernel    = pc[31];
  assign pc_plus4  = pc + 32'd4;

  always_comb begin
    exc_take   = exc & ~kernel;
    redir_take = redirect_valid & ~stall;
    irq_take   = irq & ~kernel & ~stall & ~redirect_valid & ~exc;

    sel = SEL_SEQ;
    if (exc_take)        sel = SEL_EXC;
    else if (redir_take) sel = SEL_REDIR;
    else if (irq_take)   sel = SEL_IRQ;
    else if (stall)      sel = SEL_HOLD;

    pc_next = pc_plus4;
    case (sel)
      SEL_EXC:   pc_next = EXC_VEC;
      SEL_REDIR: pc_next = redirect_pc & ~32'h3;
      SEL_IRQ:   pc_next = IRQ_VEC;
      SEL_HOLD:  pc_next = pc;
      default:   pc_next = pc_plus4;
    endcase

    // With a delay slot the word fetched alongside the redirect is kept.
    load_valid  = (sel == SEL_SEQ) || ((sel == SEL_REDIR) && (DELAY_SLOT != 0));
    ifid_hold   = (sel == SEL_HOLD);
    ifid_bubble = !load_valid && !ifid_hold;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_PC;
      epc    <= '0;
      epc_we <= 1'b0;
    end else begin
      pc     <= pc_next;
      epc_we <= 1'b0;
      if (sel == SEL_EXC) begin
        epc    <= if_id_pc_plus4;
        epc_we <= 1'b1;
      end else if (sel == SEL_IRQ) begin
        // Return to the squashed fetch so it is re-fetched after the handler.
        epc    <= pc;
        epc_we <= 1'b1;
      end
    end
  end

  if_id_reg u_if_id (
    .clk        (clk),
    .reset      (reset),
    .hold       (ifid_hold),
    .bubble     (ifid_bubble),
    .instr_d    (imem_data),
    .pc_plus4_d (pc_plus4),
    .valid      (if_id_valid),
    .instr      (if_id_instr),
    .pc_plus4   (if_id_pc_plus4)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch  <= '0;
      perf_bubble <= '0;
    end else if (load_valid) begin
      if (perf_fetch != 32'hFFFF_FFFF) perf_fetch <= perf_fetch + 32'd1;
    end else begin
      if (perf_bubble != 32'hFFFF_FFFF) perf_bubble <= perf_bubble + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: two instances (no delay slot / delay
// slot) share stimulus; each is fed by its own ROM model word = (addr>>2)+0x100.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        exc;
  logic        irq;

  logic [31:0] a_addr, a_data, a_instr, a_pc4, a_epc;
  logic        a_valid, a_epc_we, a_kernel;
  logic [31:0] b_addr, b_data, b_instr, b_pc4, b_epc;
  logic        b_valid, b_epc_we, b_kernel;
`ifdef FETCH_PERF_EN
  logic [31:0] a_pf, a_pb, b_pf, b_pb;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  assign a_data = (a_addr >> 2) + 32'h100;
  assign b_data = (b_addr >> 2) + 32'h100;

  instruction_fetch #(.DELAY_SLOT(0)) dut (
    .clk(clk), .reset(reset), .imem_addr(a_addr), .imem_data(a_data),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .exc(exc), .irq(irq), .if_id_valid(a_valid), .if_id_instr(a_instr),
    .if_id_pc_plus4(a_pc4), .epc(a_epc), .epc_we(a_epc_we), .kernel(a_kernel)
`ifdef FETCH_PERF_EN
    , .perf_fetch(a_pf), .perf_bubble(a_pb)
`endif
  );

  instruction_fetch #(.DELAY_SLOT(1)) dut_ds (
    .clk(clk), .reset(reset), .imem_addr(b_addr), .imem_data(b_data),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .exc(exc), .irq(irq), .if_id_valid(b_valid), .if_id_instr(b_instr),
    .if_id_pc_plus4(b_pc4), .epc(b_epc), .epc_we(b_epc_we), .kernel(b_kernel)
`ifdef FETCH_PERF_EN
    , .perf_fetch(b_pf), .perf_bubble(b_pb)
`endif
  );

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    exc = 1'b0; irq = 1'b0;
    step(); step();
    checks++;
    if (a_addr !== 32'h0) begin fails++; $display("FAIL reset_pc actual=%h expected=%h", a_addr, 32'h0); end
    checks++;
    if ({a_valid, a_instr, a_pc4} !== 65'h0) begin fails++; $display("FAIL reset_ifid actual=%b/%h/%h expected=0/0/0", a_valid, a_instr, a_pc4); end
    checks++;
    if ({a_epc, a_epc_we, a_kernel} !== 34'h0) begin fails++; $display("FAIL reset_epc actual=%h/%b/%b expected=0/0/0", a_epc, a_epc_we, a_kernel); end
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [4];
    logic [31:0] exp_in [4];
    exp_pc = '{32'h4, 32'h8, 32'hC, 32'h10};
    exp_in = '{32'h100, 32'h101, 32'h102, 32'h103};
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (a_addr !== exp_pc[i]) begin fails++; $display("FAIL seq_pc[%0d] actual=%h expected=%h", i, a_addr, exp_pc[i]); end
      checks++;
      if ({a_valid, a_instr, a_pc4} !== {1'b1, exp_in[i], exp_pc[i]}) begin
        fails++; $display("FAIL seq_ifid[%0d] actual=%b/%h/%h expected=1/%h/%h", i, a_valid, a_instr, a_pc4, exp_in[i], exp_pc[i]);
      end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (a_addr !== 32'h10) begin fails++; $display("FAIL stall_pc[%0d] actual=%h expected=%h", i, a_addr, 32'h10); end
      checks++;
      if ({a_valid, a_instr, a_pc4} !== {1'b1, 32'h103, 32'h10}) begin
        fails++; $display("FAIL stall_ifid[%0d] actual=%b/%h/%h expected=1/103/10", i, a_valid, a_instr, a_pc4);
      end
    end
    stall = 1'b0;
    step();
    checks++;
    if ({a_addr, a_instr, a_pc4} !== {32'h14, 32'h104, 32'h14}) begin
      fails++; $display("FAIL stall_resume actual=%h/%h/%h expected=14/104/14", a_addr, a_instr, a_pc4);
    end
  endtask

  task automatic test_redirect();
    step(); step(); step();
    checks++;
    if (a_addr !== 32'h20) begin fails++; $display("FAIL redir_setup actual=%h expected=%h", a_addr, 32'h20); end
    // Redirect under stall is ignored.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0123; stall = 1'b1;
    step();
    checks++;
    if (a_addr !== 32'h20) begin fails++; $display("FAIL redir_stalled actual=%h expected=%h", a_addr, 32'h20); end
    stall = 1'b0;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (a_addr !== 32'h120) begin fails++; $display("FAIL redir_pc actual=%h expected=%h", a_addr, 32'h120); end
    checks++;
    if ({a_valid, a_instr, a_pc4} !== 65'h0) begin fails++; $display("FAIL redir_squash actual=%b/%h/%h expected=0/0/0", a_valid, a_instr, a_pc4); end
    checks++;
    if ({b_addr, b_valid, b_instr, b_pc4} !== {32'h120, 1'b1, 32'h108, 32'h24}) begin
      fails++; $display("FAIL redir_delay_slot actual=%h/%b/%h/%h expected=120/1/108/24", b_addr, b_valid, b_instr, b_pc4);
    end
  endtask

  task automatic test_irq();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    // Deferred by stall, then taken once eligible.
    irq = 1'b1; stall = 1'b1;
    step();
    checks++;
    if ({a_addr, a_epc_we} !== {32'h40, 1'b0}) begin fails++; $display("FAIL irq_deferred actual=%h/%b expected=40/0", a_addr, a_epc_we); end
    stall = 1'b0;
    step();
    checks++;
    if ({a_addr, a_kernel, a_valid} !== {32'h8000_0004, 1'b1, 1'b0}) begin
      fails++; $display("FAIL irq_entry actual=%h/%b/%b expected=80000004/1/0", a_addr, a_kernel, a_valid);
    end
    checks++;
    if ({a_epc, a_epc_we} !== {32'h40, 1'b1}) begin fails++; $display("FAIL irq_epc actual=%h/%b expected=40/1", a_epc, a_epc_we); end
    step();
    checks++;
    if ({a_addr, a_epc_we, a_instr, a_pc4} !== {32'h8000_0008, 1'b0, 32'h2000_0101, 32'h8000_0008}) begin
      fails++; $display("FAIL irq_no_reentry actual=%h/%b/%h/%h expected=80000008/0/20000101/80000008", a_addr, a_epc_we, a_instr, a_pc4);
    end
    irq = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    checks++;
    if ({a_addr, a_kernel, a_epc_we} !== {32'h40, 1'b0, 1'b0}) begin
      fails++; $display("FAIL irq_return actual=%h/%b/%b expected=40/0/0", a_addr, a_kernel, a_epc_we);
    end
  endtask

  task automatic test_exc();
    for (int i = 0; i < 6; i++) step();
    checks++;
    if ({a_addr, a_pc4} !== {32'h58, 32'h58}) begin fails++; $display("FAIL exc_setup actual=%h/%h expected=58/58", a_addr, a_pc4); end
    exc = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200; stall = 1'b1;
    step();
    exc = 1'b0; redirect_valid = 1'b0; stall = 1'b0;
    checks++;
    if ({a_addr, a_kernel, a_valid} !== {32'h8000_0008, 1'b1, 1'b0}) begin
      fails++; $display("FAIL exc_entry actual=%h/%b/%b expected=80000008/1/0", a_addr, a_kernel, a_valid);
    end
    checks++;
    if ({a_epc, a_epc_we} !== {32'h58, 1'b1}) begin fails++; $display("FAIL exc_epc actual=%h/%b expected=58/1", a_epc, a_epc_we); end
    step();
    exc = 1'b1;
    step();
    exc = 1'b0;
    checks++;
    if ({a_addr, a_epc, a_epc_we, a_valid} !== {32'h8000_0010, 32'h58, 1'b0, 1'b1}) begin
      fails++; $display("FAIL exc_kernel_ignored actual=%h/%h/%b/%b expected=80000010/58/0/1", a_addr, a_epc, a_epc_we, a_valid);
    end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    checks++;
    if ({a_addr, a_kernel} !== {32'hFFFF_FFFC, 1'b1}) begin fails++; $display("FAIL wrap_setup actual=%h/%b expected=fffffffc/1", a_addr, a_kernel); end
    step();
    checks++;
    if ({a_addr, a_kernel, a_valid, a_instr, a_pc4} !== {32'h0, 1'b0, 1'b1, 32'h4000_00FF, 32'h0}) begin
      fails++; $display("FAIL wrap actual=%h/%b/%b/%h/%h expected=0/0/1/400000ff/0", a_addr, a_kernel, a_valid, a_instr, a_pc4);
    end
  endtask

  task automatic test_reset_mid();
    irq = 1'b1; exc = 1'b1; stall = 1'b1; reset = 1'b1;
    step();
    checks++;
    if ({a_addr, a_epc, a_epc_we, a_valid} !== {32'h0, 32'h0, 1'b0, 1'b0}) begin
      fails++; $display("FAIL reset_mid actual=%h/%h/%b/%b expected=0/0/0/0", a_addr, a_epc, a_epc_we, a_valid);
    end
    irq = 1'b0; exc = 1'b0; stall = 1'b0;
    step();
    reset = 1'b0;
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    checks++;
    if ({a_pf, a_pb} !== 64'h0) begin fails++; $display("FAIL perf_reset actual=%0d/%0d expected=0/0", a_pf, a_pb); end
    for (int i = 0; i < 10; i++) step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) step();
    stall = 1'b0;
    checks++;
    if ({a_pf, a_pb} !== {32'd10, 32'd3}) begin fails++; $display("FAIL perf_counts actual=%0d/%0d expected=10/3", a_pf, a_pb); end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_irq();
    test_exc();
    test_wrap();
    test_reset_mid();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
IF stage of the 5-stage MIPS pipeline. Owns the PC register and drives the combinational instruction ROM address. Registers the returned word into the IF/ID pipeline register. Arbitrates the next PC from sequential fetch, branch/jump redirect, exception vector and interrupt vector, and manages the kernel-mode bit (PC[31]).

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset (user program start)
IRQ_VEC, 32'h8000_0004, interrupt entry address
EXC_VEC, 32'h8000_0008, exception (illegal op) entry address
DELAY_SLOT, 0, 1 = IF instruction survives a redirect (branch delay slot); 0 = squashed

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
imem_addr  out  32  = PC register, to instruction ROM Address
imem_data  in  32  instruction word returned combinationally by ROM
stall  in  1  hazard unit: hold PC and IF/ID
redirect_valid  in  1  branch taken / j / jal / jr resolved in ID
redirect_pc  in  32  target address
exc  in  1  illegal instruction detected in ID (one-cycle pulse)
irq  in  1  timer interrupt, level
if_id_valid  out  1  IF/ID holds a real instruction
if_id_instr  out  32  registered instruction (0 = nop when bubble)
if_id_pc_plus4  out  32  registered PC+4 of that instruction
epc  out  32  saved return address
epc_we  out  1  one-cycle pulse when epc is updated
kernel  out  1  = PC[31]

Behaviour:
- Reset: PC=RESET_PC; if_id_valid=0; if_id_instr=0; if_id_pc_plus4=0; epc=0; epc_we=0. Reset mid-operation discards every pending event.
- Latency: ROM read is combinational. The instruction appears on if_id_* one clock after PC is presented.
- Bubble: if_id_valid=0, if_id_instr=0, if_id_pc_plus4=0.
- Per-cycle priority: reset > exc > redirect > irq_take > stall > sequential.
- exc (honoured only when kernel=0):
  - PC<=EXC_VEC; IF/ID<=bubble.
  - epc<=if_id_pc_plus4 (PC+4 of the offending instruction); epc_we=1.
  - Overrides stall and redirect.
  - exc while kernel=1 is ignored.
- redirect_valid:
  - If stall=1, redirect is ignored; ID holds and re-asserts it.
  - Otherwise PC<={redirect_pc[31:2],2'b00}.
  - IF/ID<=imem_data/PC+4/valid when DELAY_SLOT=1, else bubble.
- irq_take = irq & ~kernel & ~stall & ~redirect_valid & ~exc.
  - PC<=IRQ_VEC; IF/ID<=bubble; epc<=PC (the squashed fetch is re-fetched on return); epc_we=1.
  - A deferred irq is retaken on the first eligible cycle while still asserted. No internal latch; irq is level.
- stall (no exc): PC and all IF/ID outputs hold.
- Sequential: PC<=PC+4, modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000). IF/ID<={imem_data, PC+4, valid=1}.
- Kernel entry/exit:
  - Kernel is entered only via the vectors.
  - Kernel is exited only by a redirect to an address with bit31=0 (eret/jr resolved upstream).
  - J-type targets computed upstream keep PC[31:28], so kernel jumps stay in kernel.
- epc_we is 0 in every cycle without an exc/irq_take.

Optional Feature:
FETCH_PERF_EN:
- Defined: adds outputs perf_fetch[31:0] (counts cycles IF/ID loads valid=1) and perf_bubble[31:0] (counts stall, squash and vector-entry cycles).
- Both counters reset to 0, saturate at 32'hFFFF_FFFF, and are updated on the same edge as IF/ID.
- Not defined: ports and counters absent; remaining behaviour identical.

Decomposition:
- Shared package (mips_pkg): NOP_INSTR=32'h0, IRQ_VEC/EXC_VEC/RESET_PC defaults, PC width constant, and a next-PC-select enum {SEL_SEQ, SEL_REDIR, SEL_IRQ, SEL_EXC, SEL_HOLD}.
- One natural sub-module: if_id_reg (IF/ID register with hold and bubble-insert controls). The PC and next-PC mux stay in instruction_fetch.

Test Plan:
- Reset then 4 free-running cycles, ROM word k = k+0x100 -> imem_addr 0,4,8,C; if_id_instr 0x100,0x101,0x102 with pc_plus4 4,8,C; valid=1 from cycle 2.
- stall=1 for 3 cycles at PC=0x10 -> imem_addr stays 0x10, if_id outputs frozen, then resume at 0x14.
- redirect_valid with redirect_pc=0x0000_0123 at PC=0x20:
  - DELAY_SLOT=0 -> next PC=0x120, IF/ID bubble.
  - DELAY_SLOT=1 -> IF/ID holds word at 0x20 with pc_plus4=0x24.
- irq=1 at PC=0x40, kernel=0 -> PC=0x8000_0004, epc=0x40, epc_we pulse; irq held high in kernel causes no re-entry. Redirect to 0x40 returns with kernel=0.
- exc with if_id_pc_plus4=0x58 coincident with redirect and stall -> PC=0x8000_0008, epc=0x58. Repeat with kernel=1 -> exc ignored.
- PC=0xFFFF_FFFC sequential -> PC wraps to 0x0; FETCH_PERF_EN build: after 10 fetches and 3 stalls, perf_fetch=10, perf_bubble=3.
